mesh_shear_sorter: RTL and testbench



---
 rtl/mesh_shear_sorter.sv | 146 ++++++++++++++
 tb/tb_mesh_shear_sorter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_shear_sorter.sv
// ROW x COL shearsort engine: loads a key mesh on start, alternates odd-even
// transposition row and column phases, and leaves the mesh in snake order.
module mesh_shear_sorter #(
   parameter int WIDTH = 8,
   parameter int ROW   = 4,
   parameter int COL   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       descend,
   input  logic [WIDTH*ROW*COL-1:0]   in_values,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH*ROW*COL-1:0]   out_values
);

   // state | meaning
   // IDLE  | waiting for start; mesh holds the last result
   // ROWPH | row compare-exchange phase, COL steps, snake direction per row
   // COLPH | column compare-exchange phase, ROW steps, smaller key upward
   typedef enum logic [1:0] {IDLE, ROWPH, COLPH} state_t;

   localparam int NP   = $clog2(ROW);
   localparam int MAXD = (ROW > COL) ? ROW : COL;
   localparam int SW   = $clog2(MAXD);
   localparam int PW   = $clog2(NP + 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mesh_q [ROW][COL];
   logic [WIDTH-1:0]     mesh_d [ROW][COL];
   logic [WIDTH-1:0]     row_x  [ROW][COL];
   logic [WIDTH-1:0]     col_x  [ROW][COL];
   logic [SW-1:0]        step_q, step_d;
   logic [PW-1:0]        phase_q, phase_d;
   logic                 mode_q, mode_d;
   logic                 done_q, done_d;

   // Odd rows run reversed to build the snake; mode inverts every direction.
   always_comb begin
      row_x = mesh_q;
      for (int r = 0; r < ROW; r++) begin
         for (int c = 0; c < COL - 1; c++) begin
            if (c[0] == step_q[0]) begin
               if ((r[0] ^ mode_q) ? (mesh_q[r][c] < mesh_q[r][c+1])
                                   : (mesh_q[r][c] > mesh_q[r][c+1])) begin
                  row_x[r][c]   = mesh_q[r][c+1];
                  row_x[r][c+1] = mesh_q[r][c];
               end
            end
         end
      end
   end

   always_comb begin
      col_x = mesh_q;
      for (int c = 0; c < COL; c++) begin
         for (int r = 0; r < ROW - 1; r++) begin
            if (r[0] == step_q[0]) begin
               if (mode_q ? (mesh_q[r][c] < mesh_q[r+1][c])
                          : (mesh_q[r][c] > mesh_q[r+1][c])) begin
                  col_x[r][c]   = mesh_q[r+1][c];
                  col_x[r+1][c] = mesh_q[r][c];
               end
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mesh_d  = mesh_q;
      step_d  = step_q;
      phase_d = phase_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               for (int r = 0; r < ROW; r++) begin
                  for (int c = 0; c < COL; c++) begin
                     mesh_d[r][c] = in_values[(r*COL+c)*WIDTH +: WIDTH];
                  end
               end
               mode_d  = descend;
               phase_d = '0;
               step_d  = '0;
               state_d = ROWPH;
            end
         end
         ROWPH: begin
            mesh_d = row_x;
            if (step_q == SW'(COL - 1)) begin
               step_d = '0;
               if (phase_q == PW'(NP)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = COLPH;
               end
            end else begin
               step_d = step_q + SW'(1);
            end
         end
         COLPH: begin
            mesh_d = col_x;
            if (step_q == SW'(ROW - 1)) begin
               step_d  = '0;
               phase_d = phase_q + PW'(1);
               state_d = ROWPH;
            end else begin
               step_d = step_q + SW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mesh_q  <= '{default: '0};
         step_q  <= '0;
         phase_q <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mesh_q  <= mesh_d;
         step_q  <= step_d;
         phase_q <= phase_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

   for (genvar gr = 0; gr < ROW; gr++) begin : g_row
      for (genvar gc = 0; gc < COL; gc++) begin : g_col
         assign out_values[(gr*COL+gc)*WIDTH +: WIDTH] = mesh_q[gr][gc];
      end
   end

endmodule

// File: tb/tb_mesh_shear_sorter.sv
// Bench for mesh_shear_sorter: a 4x4 and an 8x4 instance checked against a
// sort-then-snake model, with handshake, reset and latency checks.
module tb_mesh_shear_sorter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         start4 = 1'b0, desc4 = 1'b0, busy4, done4;
   logic [127:0] in4 = '0, out4;
   logic         start8 = 1'b0, desc8 = 1'b0, busy8, done8;
   logic [255:0] in8 = '0, out8;

   mesh_shear_sorter #(.WIDTH(8), .ROW(4), .COL(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .descend(desc4),
      .in_values(in4), .busy(busy4), .done(done4), .out_values(out4));

   mesh_shear_sorter #(.WIDTH(8), .ROW(8), .COL(4)) u8 (
      .clk(clk), .rst(rst), .start(start8), .descend(desc8),
      .in_values(in8), .busy(busy8), .done(done8), .out_values(out8));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [255:0] expq0[$];
   logic [255:0] expq1[$];
   int ndone[2]    = '{0, 0};
   int done_cyc[2] = '{0, 0};
   int bcnt[2]     = '{0, 0};
   int nn[2]       = '{20, 40};

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: sort all keys, then deal them into rows, reversing odd rows.
   function automatic logic [255:0] model(input logic [255:0] inv, input int rows, input bit desc);
      int v[32];
      int n;
      int t;
      logic [255:0] res;
      n = rows * 4;
      for (int i = 0; i < n; i++) v[i] = int'(inv[i*8 +: 8]);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n - 1 - i; j++)
            if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      res = '0;
      for (int i = 0; i < n; i++) begin
         int r, c;
         r = i / 4;
         c = (r % 2 == 1) ? 3 - (i % 4) : (i % 4);
         res[(r*4+c)*8 +: 8] = v[i][7:0];
      end
      return res;
   endfunction

   function automatic logic [255:0] pack16(input int k[16]);
      logic [255:0] res;
      res = '0;
      for (int i = 0; i < 16; i++) res[i*8 +: 8] = k[i][7:0];
      return res;
   endfunction

   // Compare process for both instances.
   always @(negedge clk) begin
      for (int w = 0; w < 2; w++) begin
         logic d, b;
         logic [255:0] o, e;
         d = (w == 0) ? done4 : done8;
         b = (w == 0) ? busy4 : busy8;
         o = (w == 0) ? {128'b0, out4} : out8;
         if (rst) begin
            bcnt[w] = 0;
         end else if (d) begin
            chk($sformatf("busy_cycles_%0d", w), 256'(bcnt[w]), 256'(nn[w]));
            chk($sformatf("busy_at_done_%0d", w), 256'(b), 256'(0));
            if ((w == 0 ? expq0.size() : expq1.size()) == 0) begin
               checks++; errors++;
               $display("FAIL spurious_done_%0d: got done=1 expected no done", w);
            end else begin
               e = (w == 0) ? expq0.pop_front() : expq1.pop_front();
               chk($sformatf("result_%0d", w), o, e);
            end
            ndone[w]++;
            done_cyc[w] = cyc;
            bcnt[w] = 0;
         end else if (b) begin
            bcnt[w]++;
            if (bcnt[w] == nn[w] + 1) begin
               checks++; errors++;
               $display("FAIL busy_overrun_%0d: got busy beyond %0d cycles expected done", w, nn[w]);
            end
         end
      end
   end

   task automatic drive(input int w, input logic s, input bit d, input logic [255:0] v);
      if (w == 0) begin start4 = s; desc4 = d; in4 = v[127:0]; end
      else        begin start8 = s; desc8 = d; in8 = v; end
   endtask

   task automatic push(input int w, input logic [255:0] e);
      if (w == 0) expq0.push_back(e); else expq1.push_back(e);
   endtask

   // Issue one start on an idle instance; returns the cycle index of the accept edge.
   task automatic launch(input int w, input bit d, input logic [255:0] v, output int s_cyc);
      @(negedge clk);
      drive(w, 1'b1, d, v);
      @(posedge clk); #1;
      s_cyc = cyc;
      push(w, model(v, (w == 0) ? 4 : 8, d));
      @(negedge clk);
      drive(w, 1'b0, d, v);
   endtask

   task automatic wait_done(input int w, input int target);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (ndone[w] >= target) break;
      end
      if (i == 200) begin
         checks++; errors++;
         $display("FAIL done_timeout_%0d: got no done expected done %0d", w, target);
      end
   endtask

   function automatic logic [255:0] rand_keys(input int n, input bit narrow);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         v[i*8 +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      return v;
   endfunction

   initial begin
      int s0, nd;
      int k_in[16], k_asc[16], k_desc[16];
      logic [255:0] v, v2, lit;

      k_asc  = '{0,1,2,3, 7,6,5,4, 8,9,10,11, 15,14,13,12};
      k_desc = '{15,14,13,12, 8,9,10,11, 7,6,5,4, 0,1,2,3};
      for (int i = 0; i < 16; i++) k_in[i] = 15 - i;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy4", 256'(busy4), 256'(0));
      chk("reset_done4", 256'(done4), 256'(0));
      chk("reset_out4", {128'b0, out4}, '0);
      chk("reset_out8", out8, '0);
      rst = 1'b0;

      // Directed 15..0, both modes, with literal pins on the model.
      v = pack16(k_in);
      lit = pack16(k_asc);
      chk("model_asc_literal", model(v, 4, 1'b0), lit);
      launch(0, 1'b0, v, s0);
      wait_done(0, 1);
      chk("asc_latency", 256'(done_cyc[0] - s0), 256'(20));
      chk("asc_literal", {128'b0, out4}, lit);
      repeat (3) @(negedge clk);
      chk("asc_hold", {128'b0, out4}, lit);

      lit = pack16(k_desc);
      chk("model_desc_literal", model(v, 4, 1'b1), lit);
      launch(0, 1'b1, v, s0);
      wait_done(0, 2);
      chk("desc_literal", {128'b0, out4}, lit);

      // Duplicates and extremes, shuffled.
      v = '0;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = (i < 4) ? 8'hFF : (i < 8) ? 8'h00 : 8'h80;
      for (int i = 15; i > 0; i--) begin
         int j;
         logic [7:0] t;
         j = $urandom_range(0, i);
         t = v[i*8 +: 8]; v[i*8 +: 8] = v[j*8 +: 8]; v[j*8 +: 8] = t;
      end
      launch(0, 1'b0, v, s0);
      wait_done(0, 3);

      // All keys equal: nothing may move.
      v = '0;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'h5A;
      launch(0, 1'b1, v, s0);
      wait_done(0, 4);
      chk("equal_keys_unchanged", {128'b0, out4}, v);

      // Mid-sort start with other data is ignored.
      v = rand_keys(32, 1'b0);
      launch(1, 1'b0, v, s0);
      repeat (5) @(negedge clk);
      drive(1, 1'b1, 1'b1, ~v);
      @(negedge clk);
      drive(1, 1'b0, 1'b1, ~v);
      wait_done(1, 1);

      // Start held through done: back-to-back sorts.
      nd = ndone[0];
      v  = rand_keys(16, 1'b0);
      v2 = rand_keys(16, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, v);
      @(posedge clk); #1;
      s0 = cyc;
      push(0, model(v, 4, 1'b0));
      push(0, model(v2, 4, 1'b1));
      @(negedge clk);
      drive(0, 1'b1, 1'b1, v2);
      wait_done(0, nd + 1);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, v2);
      wait_done(0, nd + 2);
      chk("b2b_second_done", 256'(done_cyc[0] - s0), 256'(41));

      // Reset mid-sort at step 7.
      nd = ndone[0];
      launch(0, 1'b0, rand_keys(16, 1'b0), s0);
      while (cyc < s0 + 7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      expq0.delete();
      @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 256'(busy4), 256'(0));
      chk("rst_done", 256'(done4), 256'(0));
      chk("rst_out", {128'b0, out4}, '0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_no_done", 256'(ndone[0]), 256'(nd));
      launch(0, 1'b0, rand_keys(16, 1'b0), s0);
      wait_done(0, nd + 1);

      // Random regression on both sizes.
      for (int i = 0; i < 200; i++) begin
         int w;
         w = i % 2;
         nd = ndone[w];
         v = rand_keys((w == 0) ? 16 : 32, ($urandom_range(0, 3) == 0));
         launch(w, 1'($urandom_range(0, 1)), v, s0);
         wait_done(w, nd + 1);
      end

      repeat (3) @(negedge clk);
      chk("queue4_drained", 256'(expq0.size()), 256'(0));
      chk("queue8_drained", 256'(expq1.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
